// File: rtl/core_config.sv
// Shared encodings for the data-cache write-back AXI master: FSM states and AXI burst/response codes.
package core_config;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_RESP = 2'd3
  } wb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dcache_wb_axi_master.sv
// Drains one cache line per request as a single INCR burst on AXI AW/W/B.
// Optional macro DCACHE_WB_BRESP_CHECK_EN enables the sticky write-error flag err_o.
module dcache_wb_axi_master
  import core_config::*;
#(
  parameter int DCACHE_WIDTH   = 128,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID         = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wen_i,
  input  logic [DCACHE_WIDTH-1:0]     wdata_i,
  input  logic [31:0]                 awaddr_i,
  output logic                        free_o,
  output logic [3:0]                  awid,
  output logic [31:0]                 awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_DATA_WIDTH-1:0]   wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [3:0]                  bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  output logic                        err_o
);

  localparam int BEATS = DCACHE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  wb_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DCACHE_WIDTH-1:0]   line_q, line_d;
  logic [31:0]               addr_q, addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      WB_IDLE: begin
        if (wen_i) begin
          line_d  = wdata_i;
          addr_d  = {awaddr_i[31:4], 4'h0};
          cnt_d   = '0;
          state_d = WB_ADDR;
        end
      end
      WB_ADDR: begin
        if (awready) state_d = WB_DATA;
      end
      WB_DATA: begin
        if (wready) begin
          // Counter wraps to zero on the last beat, leaving it ready for the next line.
          cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = WB_RESP;
        end
      end
      WB_RESP: begin
        if (bvalid) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign free_o  = (state_q == WB_IDLE);
  assign awvalid = (state_q == WB_ADDR);
  assign wvalid  = (state_q == WB_DATA);
  assign bready  = (state_q == WB_RESP);

  assign awid    = 4'(AXI_ID);
  assign awaddr  = addr_q;
  assign awlen   = 8'(BEATS - 1);
  assign awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign awburst = AXI_BURST_INCR;

  assign wdata   = line_q[int'(cnt_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign wstrb   = '1;
  assign wlast   = wvalid && (cnt_q == LAST_BEAT);

`ifdef DCACHE_WB_BRESP_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q | (bvalid && bready && ((bresp != AXI_RESP_OKAY) || (bid != 4'(AXI_ID))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^awaddr_i[3:0];
`else
  assign err_o = 1'b0;

  logic unused_resp;
  assign unused_resp = ^{bid, bresp, awaddr_i[3:0]};
`endif

endmodule

// File: tb/tb_dcache_wb_axi_master.sv
// Directed and randomized bench for dcache_wb_axi_master with a line-slicing reference model.
module tb_dcache_wb_axi_master;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int BEATS = DW / AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen_i;
  logic [DW-1:0] wdata_i;
  logic [31:0]   awaddr_i;
  logic          free_o;
  logic [3:0]    awid;
  logic [31:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] wdata;
  logic [AW/8-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          err_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   accepts = 0;
  logic err_exp;
  bit   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  dcache_wb_axi_master #(.DCACHE_WIDTH(DW), .AXI_DATA_WIDTH(AW), .AXI_ID(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen_i(wen_i), .wdata_i(wdata_i), .awaddr_i(awaddr_i),
    .free_o(free_o), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && wen_i && free_o) accepts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a line becomes one burst at the 16-byte-aligned address, beat k = bits [32k+31:32k].
  task automatic do_burst(input logic [31:0] a, input logic [DW-1:0] d, input int aw_wait,
                          input int wmode, input logic [1:0] br, input logic [3:0] bi,
                          input bit hold, input logic [31:0] na, input logic [DW-1:0] nd,
                          input bit chk_min);
    int ticks;
    int k;
    int c;
    logic [31:0] ea;
    chk("free_before_accept", free_o, 1);
    wen_i = 1'b1; awaddr_i = a; wdata_i = d;
    tick();
    ticks = 0;
    if (hold) begin
      awaddr_i = na; wdata_i = nd;
    end else begin
      wen_i = 1'b0; awaddr_i = $urandom;
      wdata_i = {$urandom, $urandom, $urandom, $urandom};
    end
    ea = {a[31:4], 4'h0};
    for (int i = 0; i <= aw_wait; i++) begin
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, ea);
      chk("awlen", awlen, BEATS - 1);
      chk("awsize", awsize, 2);
      chk("awburst", awburst, 1);
      chk("awid", awid, 1);
      chk("wvalid_in_addr", wvalid, 0);
      chk("free_in_addr", free_o, 0);
      awready = (i == aw_wait);
      tick();
      ticks++;
    end
    awready = 1'b0;
    k = 0;
    c = 0;
    while (k < BEATS && c < 64) begin
      chk("wvalid", wvalid, 1);
      chk("awvalid_in_data", awvalid, 0);
      chk("wdata", wdata, DW'(32'(d >> (AW * k))));
      chk("wlast", wlast, (k == BEATS - 1));
      chk("wstrb", wstrb, 4'hf);
      case (wmode)
        0:       wready = 1'b1;
        1:       wready = pat[c % 7];
        default: wready = 1'($urandom_range(0, 1));
      endcase
      tick();
      ticks++;
      if (wready) k++;
      c++;
    end
    wready = 1'b0;
    chk("beats_done", k, BEATS);
    if (wmode == 1) chk("pattern_cycles", c, 7);
    chk("bready", bready, 1);
    chk("wvalid_in_resp", wvalid, 0);
    bvalid = 1'b1; bresp = br; bid = bi;
    tick();
    ticks++;
    bvalid = 1'b0; bresp = 2'b00; bid = 4'd1;
`ifdef DCACHE_WB_BRESP_CHECK_EN
    if (br != 2'b00 || bi != 4'd1) err_exp = 1'b1;
`endif
    chk("free_after_resp", free_o, 1);
    chk("bready_after_resp", bready, 0);
    chk("err_o", err_o, err_exp);
    if (chk_min) chk("accept_to_accept", ticks + 1, BEATS + 3);
  endtask

  initial begin
    int acc0;
    logic [DW-1:0] d1, d2, dr;
    logic [31:0]   a1, a2;

    wen_i = 0; wdata_i = '0; awaddr_i = '0; awready = 0; wready = 0;
    bid = 4'd1; bresp = 2'b00; bvalid = 0; err_exp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_free", free_o, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_err", err_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    do_burst(32'h1000_0008, 128'h44444444_33333333_22222222_11111111, 0, 0, 2'b00, 4'd1,
             0, 0, 0, 1);

    do_burst($urandom, {$urandom, $urandom, $urandom, $urandom}, 5, 0, 2'b00, 4'd1, 0, 0, 0, 0);

    do_burst($urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 2'b00, 4'd1, 0, 0, 0, 0);

    a1 = $urandom; a2 = $urandom;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    acc0 = accepts;
    do_burst(a1, d1, 0, 0, 2'b00, 4'd1, 1, a2, d2, 1);
    do_burst(a2, d2, 0, 0, 2'b00, 4'd1, 0, 0, 0, 1);
    tick();
    tick();
    chk("fifo_accepts", accepts - acc0, 2);
    chk("idle_after_fifo", free_o, 1);

    dr = {$urandom, $urandom, $urandom, $urandom};
    wen_i = 1'b1; wdata_i = dr; awaddr_i = $urandom;
    tick();
    wen_i = 1'b0;
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    chk("rst_mid_beat0", wdata, DW'(dr[31:0]));
    tick();
    chk("rst_mid_beat1", wdata, DW'(dr[63:32]));
    wready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_free", free_o, 1);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_wlast", wlast, 0);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_bready", bready, 0);
    err_exp = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    do_burst($urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 2'b00, 4'd1, 0, 0, 0, 1);

    for (int n = 0; n < 8; n++) begin
      do_burst($urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3),
               (n % 2 == 0) ? 2 : 0, 2'b00, 4'd1, 0, 0, 0, 0);
    end

    do_burst($urandom, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 2'b10, 4'd1, 0, 0, 0, 0);
    do_burst($urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 2'b00, 4'd1, 0, 0, 0, 0);
    tick();
    chk("err_sticky", err_o, err_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_wb_axi_master.md
DCACHE_WB_AXI_MASTER -- requirements
Module: dcache_wb_axi_master

Interface
REQ-001 Parameter DCACHE_WIDTH, default 128, cache-line width in bits.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, AXI W-channel width; BEATS = DCACHE_WIDTH/AXI_DATA_WIDTH (default 4).
REQ-003 Parameter AXI_ID, default 1, fixed awid value.
REQ-004 Ports (clock and reset first): clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-005 wen_i in 1 line-write request from the write-back FIFO; wdata_i in DCACHE_WIDTH line data; awaddr_i in 32 line address.
REQ-006 free_o out 1 accept strobe, wired to the FIFO's axi_bvalid_i input; a line is accepted in any cycle with wen_i && free_o.
REQ-007 AW: awid out 4, awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1.
REQ-008 W: wdata out AXI_DATA_WIDTH, wstrb out AXI_DATA_WIDTH/8, wlast out 1, wvalid out 1, wready in 1.
REQ-009 B: bid in 4, bresp in 2, bvalid in 1, bready out 1; err_o out 1 sticky write-error flag.

Function
REQ-010 FSM states: IDLE, ADDR, DATA, RESP; free_o SHALL be 1 exactly when state==IDLE, decoded from state only.
REQ-011 IDLE: on wen_i, capture wdata_i and {awaddr_i[31:4],4'h0} into line registers, clear beat counter, go to ADDR next cycle; otherwise stay.
REQ-012 ADDR: awvalid=1 with awid=AXI_ID, awlen=BEATS-1, awsize=log2(AXI_DATA_WIDTH/8), awburst=INCR (2'b01); on awready go to DATA.
REQ-013 awvalid SHALL stay asserted and AW fields stable until awready is seen.
REQ-014 DATA: wvalid=1, wstrb all ones, wdata = line slice [cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], beat 0 = lowest bits; cnt increments only on wvalid&&wready.
REQ-015 wlast SHALL be 1 only when cnt==BEATS-1; the handshake on that beat moves state to RESP.
REQ-016 W outputs SHALL be held stable while wvalid && !wready.
REQ-017 RESP: bready=1; on bvalid go to IDLE; free_o rises the following cycle, so accept-to-accept minimum is 3+BEATS cycles with zero-wait slaves.
REQ-018 wen_i SHALL be ignored outside IDLE; the line registers SHALL change only on acceptance.
REQ-019 awvalid, wvalid and bready SHALL be 0 in all states other than their own.
REQ-020 Beat counter width is clog2(BEATS) and wraps to 0 on the last beat.

Reset
REQ-021 rst_n low SHALL asynchronously force state=IDLE, cnt=0, line registers=0 and err_o=0.
REQ-022 Outputs during reset: free_o=1, awvalid=wvalid=bready=wlast=0.
REQ-023 Reset asserted mid-burst SHALL abandon the transaction without completing the handshake; the line is lost.

Configuration
REQ-024 Macro DCACHE_WB_BRESP_CHECK_EN: when defined, bresp!=2'b00 or bid!=AXI_ID on a bvalid&&bready cycle SHALL set err_o to 1 until reset; when undefined, err_o SHALL be constant 0 and bresp/bid are unused.

Structure
REQ-025 AXI burst/resp encodings (INCR, OKAY) and the state enum typedef SHALL reside in core_config.
REQ-026 The block is a single module; no sub-module.

Verification
REQ-027 Zero-wait slave: accept addr 0x1000_0008, data 0x44444444_33333333_22222222_11111111 -> awaddr 0x1000_0000, awlen 3, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, wlast on beat 4, free_o high again 7 cycles after accept.
REQ-028 awready held low 5 cycles -> awvalid/awaddr stable all 5 cycles, no wvalid before AW handshake.
REQ-029 wready toggling 1,0,0,1,0,1,1 -> exactly 4 beats in order, wdata stable across stalls.
REQ-030 wen_i held high continuously with a 2-line FIFO -> exactly one acceptance per transaction, two bursts total, no duplicated line.
REQ-031 bresp=2'b10 with macro defined -> err_o=1 and stays 1; without macro -> err_o=0.
REQ-032 rst_n pulsed low during beat 2 -> immediate IDLE, wvalid=0, free_o=1, next line starts a fresh burst at beat 0.
